// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: default widths,
// saturation limits, the MAC control states and a saturating adder that the
// requantize stages further downstream reuse.
package accel_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic                 ovf;
        logic [DEF_ACC_W-1:0] sum;
    } sat_res_t;

    // Two's complement add with one guard bit; the result clamps to the
    // nearest representable limit instead of wrapping.
    function automatic sat_res_t sat_add(input logic [DEF_ACC_W-1:0] x,
                                         input logic [DEF_ACC_W-1:0] y);
        logic [DEF_ACC_W:0] s;
        sat_res_t           r;
        s = {x[DEF_ACC_W-1], x} + {y[DEF_ACC_W-1], y};
        r.ovf = s[DEF_ACC_W] ^ s[DEF_ACC_W-1];
        if (r.ovf) begin
            r.sum = s[DEF_ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            r.sum = s[DEF_ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_mac_unit.sv
// Combinational signed multiply-accumulate with saturation. The full-width
// product is added to the accumulator with one guard bit, so any excursion
// outside the ACC_W range is detected and clamped rather than wrapped.
module sat_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  next_acc_o,
    output logic              ovf_o
);

    localparam int PW = 2 * DATA_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [PW-1:0]  a_x;
    logic [PW-1:0]  b_x;
    logic [PW-1:0]  prod;
    logic [ACC_W:0] prod_x;
    logic [ACC_W:0] acc_x;
    logic [ACC_W:0] sum;

    // Operands are sign-extended to the product width first; the low PW bits
    // of that product are the exact signed result.
    assign a_x    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_x    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod   = a_x * b_x;
    assign prod_x = {{(ACC_W+1-PW){prod[PW-1]}}, prod};
    assign acc_x  = {acc_i[ACC_W-1], acc_i};
    assign sum    = acc_x + prod_x;

    // Guard bit disagreeing with the sign bit means the sum left the range.
    always_comb begin
        ovf_o      = sum[ACC_W] ^ sum[ACC_W-1];
        next_acc_o = sum[ACC_W-1:0];
        if (ovf_o) begin
            next_acc_o = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Signed MAC stage feeding the bit_shift requantizer. A start pulse in IDLE
// latches a vector length; that many operand pairs are accumulated with
// saturation, and the result is presented until the consumer takes it.
module mac_accumulator
    import accel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   count_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [ACC_W-1:0]   acc_d;
    logic               beat_ovf;

    sat_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc_i      (acc_q),
        .a_i        (a_in),
        .b_i        (b_in),
        .next_acc_o (acc_d),
        .ovf_o      (beat_ovf)
    );

    // Control FSM; handshake flags are registered alongside the state so the
    // outputs never glitch and stay frozen while DONE waits on the consumer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        count_q <= '0;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_q | beat_ovf;
                        count_q <= count_q + LEN_W'(1);
                        if (count_q == len_q - LEN_W'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator. Expected results come
// from a plain integer model: sum the products in order, clamping to the
// 16-bit signed range after every addition.
module tb_mac_accumulator;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;
    localparam int AMAX   = (1 << (ACC_W - 1)) - 1;
    localparam int AMIN   = -(1 << (ACC_W - 1));

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;
    int a_q[$];
    int b_q[$];

    always #5 clock = ~clock;

    mac_accumulator #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(output int acc, output bit ovf);
        acc = 0;
        ovf = 1'b0;
        foreach (a_q[i]) begin
            acc = acc + a_q[i] * b_q[i];
            if (acc > AMAX) begin
                acc = AMAX;
                ovf = 1'b1;
            end else if (acc < AMIN) begin
                acc = AMIN;
                ovf = 1'b1;
            end
        end
    endfunction

    task automatic push(input int a, input int b);
        a_q.push_back(a);
        b_q.push_back(b);
    endtask

    task automatic push_rand(input int n, input bit big);
        for (int i = 0; i < n; i++) begin
            if (big) push($urandom_range(0, 1) ? 127 : -128, $urandom_range(0, 1) ? 127 : -128);
            else     push(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
    endtask

    // One full operation: start, feed the queued pairs, stall the consumer,
    // then complete the result handshake.
    task automatic run_op(input int n, input bit rand_valid, input bit noise, input int stall);
        int idx, cyc, exp_acc;
        bit exp_ovf, v;
        model(exp_acc, exp_ovf);
        @(negedge clock);
        start     = 1'b1;
        len       = LEN_W'(n);
        out_ready = 1'b0;
        in_valid  = noise;
        a_in      = DATA_W'($urandom);
        b_in      = DATA_W'($urandom);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 5000) begin
            if (idx == 0 && cyc == 0) begin
                chk("in_ready_accum", in_ready, 1);
                chk("no_early_valid", out_valid, 0);
            end
            v        = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            a_in     = v ? DATA_W'(a_q[idx]) : DATA_W'($urandom);
            b_in     = v ? DATA_W'(b_q[idx]) : DATA_W'($urandom);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                len   = LEN_W'($urandom);
            end
            @(negedge clock);
            if (v) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (cyc >= 5000) chk("beat_timeout", 0, 1);
        chk("out_valid_latency", out_valid, 1);
        chk("acc_out", acc_out, exp_acc & 32'hFFFF);
        chk("overflow", overflow, exp_ovf);
        chk("in_ready_done", in_ready, 0);
        repeat (stall) begin
            in_valid = 1'b1;
            a_in     = DATA_W'($urandom);
            b_in     = DATA_W'($urandom);
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
            chk("hold_valid", out_valid, 1);
            chk("hold_acc", acc_out, exp_acc & 32'hFFFF);
            chk("hold_ovf", overflow, exp_ovf);
            chk("hold_in_ready", in_ready, 0);
        end
        // start coinciding with the result handshake must not launch an op
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = LEN_W'(3);
        @(negedge clock);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("idle_after_hs", busy, 0);
        a_q.delete();
        b_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);

        // basic sum: 6 - 20 + 49 = 35
        push(2, 3); push(-4, 5); push(7, 7);
        run_op(3, 1'b0, 1'b0, 0);

        // positive clamp, then a fresh op clears overflow
        repeat (3) push(127, 127);
        run_op(3, 1'b0, 1'b0, 0);
        push(1, 1);
        run_op(1, 1'b0, 1'b0, 0);

        // negative clamp
        repeat (3) push(-128, 127);
        run_op(3, 1'b0, 1'b0, 0);

        // accumulation resumes from the clamp; overflow stays sticky
        repeat (3) push(127, 127);
        push(-128, 127);
        run_op(4, 1'b0, 1'b0, 0);

        // handshake stress: gappy input, stray starts, long consumer stall
        push_rand(4, 1'b0);
        run_op(4, 1'b1, 1'b1, 10);

        // zero length
        run_op(0, 1'b0, 1'b1, 2);

        // reset after 2 of 5 beats
        push_rand(5, 1'b0);
        @(negedge clock);
        start = 1'b1;
        len   = LEN_W'(5);
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_in     = DATA_W'(a_q[i]);
            b_in     = DATA_W'(b_q[i]);
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_acc_out", acc_out, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clock);
        chk("mid_rst_no_valid", out_valid, 0);
        a_q.delete();
        b_q.delete();
        push(3, 3); push(1, 1);
        run_op(2, 1'b0, 1'b0, 0);

        // random operations of assorted lengths and operand magnitudes
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(1, 30);
            push_rand(n, 1'($urandom_range(0, 1)));
            run_op(n, 1'b1, 1'b1, $urandom_range(0, 3));
        end

        // maximum length
        push_rand(255, 1'b1);
        run_op(255, 1'b0, 1'b0, 1);
        push_rand(255, 1'b0);
        run_op(255, 1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Signed int8 x int8 multiply-accumulate stage that sits directly upstream of bit_shift. For each operation it consumes a programmed number of operand pairs over a valid/ready stream. It produces one saturated 16-bit accumulator word, which bit_shift then requantizes to 8 bits. Downstream shift_amount/shift_direction are not handled here.

Parameters:
DATA_W, 8, operand width (signed two's complement)
ACC_W, 16, accumulator/result width (signed); must be >= 2*DATA_W
LEN_W, 8, width of the vector-length field

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins an operation; honoured only in IDLE
len  input  LEN_W  number of operand pairs for the operation, sampled on accepted start
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operand pair this cycle
a_in  input  DATA_W  signed operand A
b_in  input  DATA_W  signed operand B
out_valid  output  1  acc_out holds a final result
out_ready  input  1  consumer (bit_shift stage) takes result
acc_out  output  ACC_W  saturated signed accumulation result
overflow  output  1  result saturated at least once during this operation; valid with out_valid
busy  output  1  high in ACCUM or DONE

Behaviour:
- One clock, reset synchronous active-high. On reset: state=IDLE, acc=0, count=0, in_ready=0, out_valid=0, acc_out=0, overflow=0, busy=0.
- States:
  - IDLE: start=1 -> latch len, clear acc and overflow. Go to ACCUM if len!=0, else go to DONE with acc=0.
  - ACCUM: in_ready=1. Beat accepted when in_valid&in_ready. On each beat acc <= sat(acc + a_in*b_in) and count increments. The beat where count reaches len goes to DONE.
  - DONE: in_ready=0, out_valid=1, acc_out=acc. Hold every output stable until out_valid&out_ready, then go to IDLE. out_valid drops the following cycle.
- Arithmetic:
  - The product is the full signed 2*DATA_W value, sign-extended to ACC_W+1 bits for the sum.
  - If the sum > 2^(ACC_W-1)-1, clamp to 0x7FFF and set overflow. If the sum < -2^(ACC_W-1), clamp to 0x8000 and set overflow.
  - Overflow is sticky until the next accepted start.
  - Accumulation continues from the clamped value; there is no wrap-around ever.
- Latency: out_valid rises the cycle after the last accepted beat, or the cycle after start when len=0. Minimum issue interval is len+2 cycles.
- start while busy=1 is ignored and does not alter len, acc or count.
- in_valid with no accepted start (IDLE or DONE) is ignored; in_ready=0 there.
- Upstream stalls (in_valid low) in ACCUM simply pause; there is no timeout.
- Downstream stall: acc_out/overflow/out_valid held indefinitely while out_ready=0.
- start in the same cycle as the DONE handshake is ignored. A new operation begins only from IDLE.
- Reset asserted mid-operation aborts immediately to the reset state. The partial sum is discarded and no out_valid is produced.
- len max = 2^LEN_W-1.

Decomposition:
- Shared package accel_pkg:
  - state enum (IDLE, ACCUM, DONE)
  - DATA_W/ACC_W defaults
  - ACC_MAX/ACC_MIN saturation constants
  - a sat_add function reused by later requantize stages
- One sub-module is natural: sat_mac_unit. It is purely combinational: it takes acc, a and b, and returns next_acc plus an ovf flag. It is instantiated once; the FSM, counter and handshake stay in the top.

Test Plan:
1. Basic sum: start len=3, beats (2,3),(-4,5),(7,7) with in_valid continuous -> out_valid 1 cycle after 3rd beat, acc_out=0x0023 (35), overflow=0.
2. Positive saturation: len=3, three beats (127,127) -> acc_out=0x7FFF, overflow=1. Then start len=1 with beat (1,1) -> acc_out=0x0001, overflow=0.
3. Negative saturation: len=3, three beats (-128,127) -> acc_out=0x8000, overflow=1. Clamp holds after the 3rd beat; no wrap to a positive value.
4. Handshake stress:
   - len=4 with in_valid toggling randomly -> result only counts accepted beats.
   - out_ready low 10 cycles -> acc_out/out_valid stable, in_ready=0.
   - Extra start pulses during the op are ignored.
5. Zero length: start len=0 -> out_valid=1, acc_out=0x0000 the next cycle, overflow=0, no beats consumed.
6. Reset mid-operation: reset after 2 of 5 beats -> all outputs 0 next cycle. A new start len=2 with beats (3,3),(1,1) gives acc_out=0x000A.
